bit_serializer: RTL and testbench

- Upstream feeder for the serial pattern-detection stage.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out one bit per clock on the `data` line, which the detector samples every cycle.
- Back-to-back words stream with no gaps; an empty buffer drives a fixed idle level.

---
 rtl/bit_serializer.sv | 150 +++++++++++++++
 tb/tb_bit_serializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: words enter a small FIFO over valid/ready and are
// shifted out one bit per clock on `data`, back-to-back with no gap between words.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             data_valid,
    output logic             busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             load;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic             data_nxt;
    logic             data_valid_nxt;

    // in_ready deliberately ignores a same-cycle pop.
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = data_valid || (count != '0);

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            data       <= IDLE_LEVEL;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            data       <= data_nxt;
            data_valid <= data_valid_nxt;
        end
    end

    // Pop decisions look only at the registered count, so there is no bypass path.
    always_comb begin
        state_nxt      = state;
        sreg_nxt       = sreg;
        bit_cnt_nxt    = bit_cnt;
        data_nxt       = data;
        data_valid_nxt = data_valid;
        load           = 1'b0;
        pop            = 1'b0;

        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt != '0) begin
                    bit_cnt_nxt = bit_cnt - BW'(1);
                    if (MSB_FIRST) begin
                        data_nxt = sreg[WIDTH-1];
                        sreg_nxt = sreg << 1;
                    end else begin
                        data_nxt = sreg[0];
                        sreg_nxt = sreg >> 1;
                    end
                end else if (count != '0) begin
                    load = 1'b1;
                end else begin
                    state_nxt      = ST_IDLE;
                    data_nxt       = IDLE_LEVEL;
                    data_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // The first bit goes straight to `data`; sreg keeps the remaining bits.
        if (load) begin
            pop            = 1'b1;
            state_nxt      = ST_SHIFT;
            bit_cnt_nxt    = BW'(WIDTH - 1);
            data_valid_nxt = 1'b1;
            if (MSB_FIRST) begin
                data_nxt = head[WIDTH-1];
                sreg_nxt = head << 1;
            end else begin
                data_nxt = head[0];
                sreg_nxt = head >> 1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, expected
// bits queued at each accepted handshake and popped whenever data_valid is seen.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_word_m, in_word_l;
    logic       in_valid_m, in_valid_l;
    logic       rdy_m, data_m, dv_m, busy_m;
    logic       rdy_l, data_l, dv_l, busy_l;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   q_m[$];
    bit   q_l[$];
    int   cycn    = 0;
    int   vcnt    = 0;
    int   vcnt_l  = 0;
    int   first_v = -1;
    int   last_v  = -1;
    int   e0      = 0;
    int   idx     = 0;
    logic acc_m   = 1'b0;
    logic [15:0] cap_m = '0;
    logic [15:0] cap_l = '0;
    logic [7:0]  ww [10];

    bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
        .clk(clk), .reset(reset), .in_word(in_word_m), .in_valid(in_valid_m),
        .in_ready(rdy_m), .data(data_m), .data_valid(dv_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk(clk), .reset(reset), .in_word(in_word_l), .in_valid(in_valid_l),
        .in_ready(rdy_l), .data(data_l), .data_valid(dv_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        bit exp_b;
        if (dv_m) begin
            vcnt++;
            if (first_v < 0) first_v = cycn;
            last_v = cycn;
            cap_m  = {cap_m[14:0], data_m};
            if (q_m.size() > 0) begin
                exp_b = q_m.pop_front();
                check("msb_bit", 32'(data_m), 32'(exp_b));
            end else begin
                check("msb_unexpected_bit", 32'(data_m), 32'hx);
            end
        end else begin
            check("msb_idle_level", 32'(data_m), 32'd1);
        end
        if (dv_l) begin
            vcnt_l++;
            cap_l = {cap_l[14:0], data_l};
            if (q_l.size() > 0) begin
                exp_b = q_l.pop_front();
                check("lsb_bit", 32'(data_l), 32'(exp_b));
            end else begin
                check("lsb_unexpected_bit", 32'(data_l), 32'hx);
            end
        end else begin
            check("lsb_idle_level", 32'(data_l), 32'd1);
        end
    endtask

    // Drive inputs at the falling edge, record any handshake, cross one rising edge.
    task automatic step(input logic vm = 1'b0, input logic [7:0] wm = 8'h00,
                        input logic vl = 1'b0, input logic [7:0] wl = 8'h00);
        in_valid_m = vm;
        in_word_m  = wm;
        in_valid_l = vl;
        in_word_l  = wl;
        acc_m      = vm && rdy_m;
        if (acc_m) begin
            for (int i = 7; i >= 0; i--) q_m.push_back(wm[i]);
        end
        if (vl && rdy_l) begin
            for (int i = 0; i < 8; i++) q_l.push_back(wl[i]);
        end
        @(posedge clk);
        @(negedge clk);
        cycn++;
        sample();
    endtask

    task automatic open_window();
        vcnt    = 0;
        vcnt_l  = 0;
        first_v = -1;
        last_v  = -1;
        cap_m   = '0;
        cap_l   = '0;
    endtask

    task automatic close_window(input string tag, input int nbits);
        check({tag, "_valid_count"}, 32'(vcnt), 32'(nbits));
        check({tag, "_contiguous"}, 32'(last_v - first_v + 1), 32'(nbits));
        check({tag, "_first_bit_latency"}, 32'(first_v), 32'(e0 + 1));
        check({tag, "_scoreboard_empty"}, 32'(q_m.size()), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid_m = 1'b0;
        in_valid_l = 1'b0;
        in_word_m  = '0;
        in_word_l  = '0;
        #2;
        check("reset_data", 32'(data_m), 32'd1);
        check("reset_data_valid", 32'(dv_m), 32'd0);
        check("reset_busy", 32'(busy_m), 32'd0);
        check("reset_in_ready", 32'(rdy_m), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Single word 0x2B, MSB first.
        open_window();
        step(1'b1, 8'h2B);
        e0 = cycn;
        check("single_no_bypass", 32'(dv_m), 32'd0);
        step();
        check("single_busy_during", 32'(busy_m), 32'd1);
        repeat (9) step();
        close_window("single", 8);
        check("single_stream", 32'(cap_m[7:0]), 32'h2B);
        check("single_idle_data", 32'(data_m), 32'd1);
        check("single_idle_busy", 32'(busy_m), 32'd0);

        // Two back-to-back words, no gap at the word boundary.
        open_window();
        step(1'b1, 8'hA5);
        e0 = cycn;
        step(1'b1, 8'h3C);
        repeat (18) step();
        close_window("b2b", 16);
        check("b2b_stream", 32'(cap_m), 32'hA53C);

        // Backpressure: five words fill the buffer, the sixth waits for a pop.
        open_window();
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_while_filling", 32'(rdy_m), 32'd1);
            step(1'b1, 8'(8'h11 * (i + 1)));
            if (i == 0) e0 = cycn;
        end
        check("bp_full_after_e4", 32'(rdy_m), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check("bp_ready_held_low", 32'(rdy_m), 32'd0);
            step(1'b1, 8'h66);
        end
        check("bp_ready_after_e9", 32'(rdy_m), 32'd1);
        step(1'b1, 8'h66);
        repeat (45) step();
        close_window("bp", 48);

        // Asynchronous reset while the 4th bit of 0xFF shifts with two words queued.
        open_window();
        step(1'b1, 8'hFF);
        step(1'b1, 8'h81);
        step(1'b1, 8'h7E);
        step();
        step();
        check("rst_mid_shifting", 32'(dv_m), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_data", 32'(data_m), 32'd1);
        check("rst_async_data_valid", 32'(dv_m), 32'd0);
        check("rst_async_busy", 32'(busy_m), 32'd0);
        check("rst_async_in_ready", 32'(rdy_m), 32'd1);
        q_m.delete();
        step();
        step();
        reset = 1'b0;
        // First edge after release accepts; nothing from before the reset reappears.
        open_window();
        step(1'b1, 8'h5A);
        e0 = cycn;
        repeat (11) step();
        close_window("post_rst", 8);
        check("post_rst_stream", 32'(cap_m[7:0]), 32'h5A);

        // LSB-first instance.
        open_window();
        step(1'b0, 8'h00, 1'b1, 8'h2B);
        repeat (10) step();
        check("lsb_valid_count", 32'(vcnt_l), 32'd8);
        check("lsb_stream", 32'(cap_l[7:0]), 32'hD4);
        check("lsb_scoreboard_empty", 32'(q_l.size()), 32'd0);

        // Ten words through the 4-deep buffer with in_valid on every other cycle.
        for (int i = 0; i < 10; i++) ww[i] = 8'(i * 37 + 5);
        open_window();
        idx = 0;
        for (int c = 0; c < 200 && idx < 10; c++) begin
            if (c % 2 == 0) begin
                step(1'b1, ww[idx]);
                if (c == 0) e0 = cycn;
                if (acc_m) idx++;
            end else begin
                step();
            end
        end
        check("wrap_all_accepted", 32'(idx), 32'd10);
        repeat (90) step();
        close_window("wrap", 80);
        check("wrap_final_busy", 32'(busy_m), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
